// File: rtl/mem_dump_ctrl_pkg.sv
// Shared state encoding and command-mode constants for the memory dump/load controller.
package mem_dump_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StRdSend,
    StLd,
    StFin
  } state_e;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/mem_dump_ctrl.sv
// Console-port controller: streams a wrapping word range out of memory (DUMP)
// or writes an incoming stream into it (LOAD).
module mem_dump_ctrl
  import mem_dump_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] con_addr,
  output logic [3:0]        con_write,
  output logic [DATA_W-1:0] con_in,
  input  logic [DATA_W-1:0] con_out,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              xfer_done
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_end;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_valid;
  logic              r_m_last;
  logic              r_s_ready;
  logic              r_busy;
  logic              r_xfer_done;

  logic              w_at_end;
  logic              w_ld_fire;
  logic [ADDR_W-1:0] w_addr_inc;

  assign w_at_end   = (r_addr == r_end);
  assign w_addr_inc = r_addr + 1'b1;
  // abort wins over a same-cycle LOAD handshake, so the word is never written
  assign w_ld_fire  = r_s_ready & s_valid & ~abort;

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_end       <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_s_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_xfer_done <= 1'b0;
    end else begin
      r_xfer_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_addr <= start_addr;
            r_end  <= end_addr;
            r_busy <= 1'b1;
            if (mode == MODE_DUMP) begin
              r_state <= StRdIssue;
            end else begin
              r_state   <= StLd;
              r_s_ready <= 1'b1;
            end
          end
        end
        StRdIssue: begin
          if (abort) begin
            r_state     <= StFin;
            r_xfer_done <= 1'b1;
          end else begin
            r_state <= StRdWait;
          end
        end
        StRdWait: begin
          if (abort) begin
            r_state     <= StFin;
            r_xfer_done <= 1'b1;
          end else begin
            r_m_data  <= con_out;
            r_m_valid <= 1'b1;
            r_m_last  <= w_at_end;
            r_state   <= StRdSend;
          end
        end
        StRdSend: begin
          if (abort) begin
            r_state     <= StFin;
            r_xfer_done <= 1'b1;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
          end else if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (w_at_end) begin
              r_state     <= StFin;
              r_xfer_done <= 1'b1;
            end else begin
              r_addr  <= w_addr_inc;
              r_state <= StRdIssue;
            end
          end
        end
        StLd: begin
          if (abort) begin
            r_state     <= StFin;
            r_xfer_done <= 1'b1;
            r_s_ready   <= 1'b0;
          end else if (s_valid) begin
            if (w_at_end) begin
              r_state     <= StFin;
              r_xfer_done <= 1'b1;
              r_s_ready   <= 1'b0;
            end else begin
              r_addr <= w_addr_inc;
            end
          end
        end
        StFin: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= StIdle;
          r_busy    <= 1'b0;
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  // addr only moves while busy, so it also serves as the held console address in IDLE
  assign con_addr  = r_addr;
  assign con_write = w_ld_fire ? 4'hF : 4'h0;
  assign con_in    = w_ld_fire ? s_data : '0;
  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_last    = r_m_last;
  assign busy      = r_busy;
  assign xfer_done = r_xfer_done;

endmodule

// File: doc/mem_dump_ctrl.md
MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning console word-address width (data memory depth 2^ADDR_W = 1024 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning memory word width.
REQ-003 SHALL have ports, clock and reset first, one per line as below:
  CLK  in  1  sole clock; all state changes on rising edge.
  nrst  in  1  reset, asynchronous, active-low.
  start  in  1  one-cycle command pulse.
  mode  in  1  0 = DUMP (memory to stream), 1 = LOAD (stream to memory); sampled with start.
  start_addr  in  ADDR_W  first word address; sampled with start.
  end_addr  in  ADDR_W  last word address, inclusive; sampled with start.
  abort  in  1  cancel the active transfer.
  con_addr  out  ADDR_W  memory console word address.
  con_write  out  4  byte write enables.
  con_in  out  DATA_W  memory write data.
  con_out  in  DATA_W  memory read data, valid one cycle after con_addr.
  s_valid / s_ready / s_data  in / out / in  1 / 1 / DATA_W  LOAD input stream.
  m_valid / m_ready / m_data / m_last  out / in / out / out  1 / 1 / DATA_W / 1  DUMP output stream.
  busy  out  1  transfer in progress.
  xfer_done  out  1  one-cycle pulse on completion or abort.

Function
REQ-004 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, RD_SEND, LD, FIN.
REQ-005 IDLE SHALL accept start: mode=0 -> RD_ISSUE, mode=1 -> LD; addr register <= start_addr; end register <= end_addr.
REQ-006 start SHALL be ignored in every state other than IDLE.
REQ-007 RD_ISSUE SHALL drive con_addr = addr and go to RD_WAIT next cycle.
REQ-008 RD_WAIT SHALL capture con_out into m_data at the clock edge and go to RD_SEND.
REQ-009 RD_SEND SHALL hold m_valid=1 and m_data stable until m_ready=1.
REQ-010 On the RD_SEND handshake, the FSM SHALL go to FIN when addr == end, else to RD_ISSUE with addr+1.
REQ-011 m_last SHALL be 1 exactly while RD_SEND presents the word at addr == end.
REQ-012 Minimum DUMP throughput SHALL be one word per 3 cycles with m_ready held at 1.
REQ-013 LD SHALL assert s_ready=1. On s_valid&&s_ready, in the same cycle: con_write=4'hF, con_in=s_data, con_addr=addr.
REQ-014 After an LD transfer, the FSM SHALL go to FIN when addr == end, else increment addr.
REQ-015 con_write SHALL be 4'h0 in every cycle without an LD handshake.
REQ-016 Address increment SHALL wrap modulo 2^ADDR_W. start_addr == end_addr transfers 1 word; end_addr == start_addr-1 transfers 1024 words.
REQ-017 FIN SHALL pulse xfer_done=1 for one cycle, then go to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 abort in any non-IDLE state SHALL go to FIN next cycle, with no further memory write and no further m_valid.
REQ-020 abort SHALL take priority over a same-cycle handshake, so the word is dropped and not written.
REQ-021 m_valid and s_ready SHALL never be 1 simultaneously.
REQ-022 In IDLE, con_addr SHALL hold its last value, con_write = 0, m_valid = 0, s_ready = 0.

Reset
REQ-023 nrst low SHALL asynchronously force state IDLE and set to zero: addr, end, con_addr, con_write, con_in, m_data, m_valid, m_last, s_ready, busy, xfer_done.
REQ-024 Reset asserted mid-transfer SHALL abandon the transfer with no xfer_done pulse, and memory writes SHALL stop immediately.

Structure
REQ-025 The state encoding and the mode constants (MODE_DUMP, MODE_LOAD) SHALL live in the shared core package.
REQ-026 The block SHALL be a single module with no sub-modules; the address counter with wrap-compare is inline.

Verification
REQ-027 DUMP 0x000..0x003 with m_ready=1 and memory preloaded with 0xA0..0xA3 -> stream 0xA0,0xA1,0xA2,0xA3; m_last on 0xA3 only; xfer_done 12-13 cycles after start.
REQ-028 LOAD 0x3FE..0x001 with 4 words 0x11..0x44 -> addresses 0x3FE,0x3FF,0x000,0x001 written with con_write=4'hF; then one xfer_done pulse.
REQ-029 DUMP with m_ready toggled 0/1 every cycle -> m_data stable while m_valid && !m_ready; no word lost or duplicated.
REQ-030 abort in the same cycle as the LD handshake on the 2nd word -> only the 1st word written; xfer_done next cycle; busy falls after.
REQ-031 start pulsed during an active DUMP -> ignored; the original range completes unchanged.
REQ-032 nrst dropped during RD_SEND -> all outputs zero asynchronously; a new start after release begins cleanly from IDLE.
